// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register word codes,
// status bit positions and the request sequencer state encoding.
package irq_ctrl_pkg;

    // Register window word select codes (add[3:2])
    localparam logic [1:0] ADD_MASK = 2'b00;
    localparam logic [1:0] ADD_PEND = 2'b01;
    localparam logic [1:0] ADD_STAT = 2'b10;
    localparam logic [1:0] ADD_EOI  = 2'b11;

    // Bit positions inside MASK and STATUS
    localparam int GIE_BIT   = 31;
    localparam int INSVC_BIT = 31;
    localparam int REQ_BIT   = 30;

    // Request sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req and whether
// any bit is set. Index 0 is the highest priority.
module irq_prio_enc #(
    parameter int NSRC = 6,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  id,
    output logic            vld
);

    // Scan from the top down so the lowest set index is the last one kept
    always_comb begin
        id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) id = IDW'(i);
        end
    end

    assign vld = |req;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges of device lines into PENDING,
// masks and arbitrates them, and walks the winner through
// request -> acknowledge -> in-service -> end-of-interrupt.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 6,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:2]      add,
    input  logic            we,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    input  logic [NSRC-1:0] dev_irq,
    output logic            int_req,
    input  logic            int_ack,
    output logic [IDW-1:0]  int_id
);

    logic [NSRC-1:0] mask_en;
    logic            gie;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] event_v;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] id_onehot;
    logic [IDW-1:0]  win_id;
    logic            win_vld;
    logic [IDW-1:0]  int_id_nx;
    logic            wr_mask, wr_pend, wr_eoi, ack_taken;
    logic            unused_din;
    state_t          state, state_nx;

    assign wr_mask   = we && (add == ADD_MASK);
    assign wr_pend   = we && (add == ADD_PEND);
    assign wr_eoi    = we && (add == ADD_EOI);
    assign ack_taken = (state == S_REQ) && int_ack;

    assign id_onehot = NSRC'(1) << int_id;
    assign event_v   = dev_irq & ~irq_q;
    assign w1c       = wr_pend ? din[NSRC-1:0] : '0;
    assign ack_clr   = ack_taken ? id_onehot : '0;
    assign eligible  = gie ? (pending & mask_en) : '0;

    // Only the low source bits and GIE of din are stored anywhere
    assign unused_din = ^din;

    irq_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio (
        .req (eligible),
        .id  (win_id),
        .vld (win_vld)
    );

    // Line history follows dev_irq even during reset, so a line held high
    // across reset is seen as already high and yields no event afterwards
    always_ff @(posedge clk) begin
        irq_q <= dev_irq;
    end

    // MASK and PENDING registers; a new edge wins over any clear
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_en <= '0;
            gie     <= 1'b0;
            pending <= '0;
        end else begin
            if (wr_mask) begin
                mask_en <= din[NSRC-1:0];
                gie     <= din[GIE_BIT];
            end
            pending <= (pending & ~w1c & ~ack_clr) | event_v;
        end
    end

    // Sequencer state and latched source id
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            int_id <= '0;
        end else begin
            state  <= state_nx;
            int_id <= int_id_nx;
        end
    end

    // Next state: ack beats loss of eligibility in REQ; id clears on return to IDLE
    always_comb begin
        state_nx  = state;
        int_id_nx = int_id;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nx  = S_REQ;
                    int_id_nx = win_id;
                end
            end
            S_REQ: begin
                if (ack_taken) begin
                    state_nx = S_SVC;
                end else if ((eligible & id_onehot) == '0) begin
                    state_nx  = S_IDLE;
                    int_id_nx = '0;
                end
            end
            S_SVC: begin
                if (wr_eoi) begin
                    state_nx  = S_IDLE;
                    int_id_nx = '0;
                end
            end
            default: begin
                state_nx  = S_IDLE;
                int_id_nx = '0;
            end
        endcase
    end

    assign int_req = (state == S_REQ);

    // Register read mux, purely combinational from add
    always_comb begin
        dout = '0;
        case (add)
            ADD_MASK: begin
                dout[NSRC-1:0] = mask_en;
                dout[GIE_BIT]  = gie;
            end
            ADD_PEND: dout[NSRC-1:0] = pending;
            ADD_STAT: begin
                dout[INSVC_BIT] = (state == S_SVC);
                dout[REQ_BIT]   = int_req;
                dout[IDW-1:0]   = int_id;
            end
            default: dout = '0;
        endcase
    end

endmodule
